// File: rtl/etroc_stream_pkg.sv
// etroc_stream_pkg: frame identifiers, checker states, frame classes and error codes
package etroc_stream_pkg;
    localparam logic [17:0] FILLER_ID = {16'h3C5C, 2'b10};
    localparam logic [17:0] HEADER_ID = {16'h3C5C, 2'b00};
    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_SEQ_DATA    = 3'd1;
    localparam logic [2:0] ERR_SEQ_TRAILER = 3'd2;
    localparam logic [2:0] ERR_HIT_OVF     = 3'd3;
    localparam logic [2:0] ERR_CHIPID      = 3'd4;
    typedef enum logic [2:0] {UNKNOWN, FILLER, HEADER, DATA, TRAILER, RESYNC} streamState_t;
    typedef enum logic [1:0] {CLS_FILLER, CLS_HEADER, CLS_DATA, CLS_TRAILER} frameClass_t;
    function automatic frameClass_t classify(input logic [17:0] checkField);
        return checkField[17] ? CLS_DATA :
               checkField == FILLER_ID ? CLS_FILLER :
               checkField == HEADER_ID ? CLS_HEADER : CLS_TRAILER;
    endfunction
endpackage

// File: rtl/etroc_sat_counter.sv
// etroc_sat_counter: counter that sticks at all-ones; clear beats increment
module etroc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk40,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk40) begin
        if (reset || clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/etroc_stream_checker.sv
// etroc_stream_checker: ETROC frame-sequence checker with one-frame resync,
// hit limit, chip-ID consistency and saturating error/packet counters
module etroc_stream_checker
    import etroc_stream_pkg::*;
#(
    parameter int MAX_HITS     = 256,
    parameter int CNT_W        = 16,
    parameter bit CHIPID_CHECK = 1
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic             dataValid,
    input  logic [39:0]      din,
    input  logic             clearCounters,
    output logic             noError,
    output logic [2:0]       errCode,
    output logic [CNT_W-1:0] errCount,
    output logic [CNT_W-1:0] packetCount,
    output logic             chipIdError,
    output logic [16:0]      refChipId
);
    localparam int HW = $clog2(MAX_HITS + 1);
    localparam logic [HW-1:0] HIT_MAX = HW'(MAX_HITS);

    streamState_t state, stateNext;
    frameClass_t  cls;
    logic [HW-1:0] hitCnt, hitNext;
    logic          seqErr, trailerAcc, refValid, chipMismatch;
    logic [2:0]    errNext;

    assign cls = classify(din[39:22]);
    assign chipMismatch = CHIPID_CHECK && trailerAcc && refValid && din[38:22] != refChipId;

    always_comb begin
        stateNext  = state;
        hitNext    = hitCnt;
        seqErr     = 1'b0;
        errNext    = ERR_NONE;
        trailerAcc = 1'b0;
        case (state)
            UNKNOWN: begin
                stateNext  = cls == CLS_FILLER ? FILLER : cls == CLS_HEADER ? HEADER :
                             cls == CLS_DATA ? DATA : TRAILER;
                hitNext    = cls == CLS_HEADER ? '0 : cls == CLS_DATA ? hitCnt + 1'b1 : hitCnt;
                trailerAcc = cls == CLS_TRAILER;
            end
            HEADER, DATA: begin
                // overflow takes precedence over the class check
                if (cls == CLS_DATA && hitCnt == HIT_MAX) begin
                    seqErr  = 1'b1;
                    errNext = ERR_HIT_OVF;
                end else if (cls == CLS_DATA) begin
                    stateNext = DATA;
                    hitNext   = hitCnt + 1'b1;
                end else if (cls == CLS_TRAILER) begin
                    stateNext  = TRAILER;
                    trailerAcc = 1'b1;
                end else begin
                    seqErr  = 1'b1;
                    errNext = ERR_SEQ_DATA;
                end
            end
            FILLER, TRAILER: begin
                if (cls == CLS_HEADER) begin
                    stateNext = HEADER;
                    hitNext   = '0;
                end else if (cls == CLS_FILLER) begin
                    stateNext = FILLER;
                end else begin
                    seqErr  = 1'b1;
                    errNext = ERR_SEQ_TRAILER;
                end
            end
            RESYNC: begin
                stateNext = UNKNOWN;
                hitNext   = '0;
            end
            default: stateNext = UNKNOWN;
        endcase
        if (seqErr) stateNext = RESYNC;
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            state   <= UNKNOWN;
            hitCnt  <= '0;
            noError <= 1'b1;
        end else if (dataValid) begin
            state   <= stateNext;
            hitCnt  <= hitNext;
            noError <= !seqErr;
        end
    end

    always_ff @(posedge clk40) begin
        if (reset || clearCounters) begin
            errCode     <= ERR_NONE;
            chipIdError <= 1'b0;
            refChipId   <= '0;
            refValid    <= 1'b0;
        end else if (dataValid) begin
            if (seqErr) errCode <= errNext;
            else if (chipMismatch) begin
                errCode     <= ERR_CHIPID;
                chipIdError <= 1'b1;
            end
            if (trailerAcc && !refValid) begin
                refChipId <= din[38:22];
                refValid  <= 1'b1;
            end
        end
    end

    etroc_sat_counter #(.W(CNT_W)) errCounter (
        .clk40(clk40), .reset(reset), .inc(dataValid && seqErr), .clr(clearCounters), .count(errCount)
    );

    etroc_sat_counter #(.W(CNT_W)) packetCounter (
        .clk40(clk40), .reset(reset), .inc(dataValid && trailerAcc), .clr(clearCounters), .count(packetCount)
    );
endmodule

// File: tb/tb_etroc_stream_checker.sv
// tb_etroc_stream_checker: directed sequence against hand-computed expectations
module tb_etroc_stream_checker;
    localparam logic [39:0] FILL = {16'h3C5C, 2'b10, 22'h0};
    localparam logic [39:0] HDR  = {16'h3C5C, 2'b00, 22'h0};
    localparam logic [39:0] DAT  = {1'b1, 39'h12345};

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic        dataValid = 1'b0;
    logic [39:0] din = '0;
    logic        clearCounters = 1'b0;
    logic        noError, chipIdError;
    logic [2:0]  errCode;
    logic [3:0]  errCount, packetCount;
    logic [16:0] refChipId;
    int nAsserts = 0;
    int nFail = 0;

    etroc_stream_checker #(.MAX_HITS(4), .CNT_W(4), .CHIPID_CHECK(1)) dut (
        .clk40(clk40), .reset(reset), .dataValid(dataValid), .din(din),
        .clearCounters(clearCounters), .noError(noError), .errCode(errCode),
        .errCount(errCount), .packetCount(packetCount), .chipIdError(chipIdError),
        .refChipId(refChipId)
    );

    always #12 clk40 = ~clk40;

    function automatic logic [39:0] trl(input logic [16:0] id);
        return {1'b0, id, 22'h2AA};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [39:0] f);
        dataValid = 1'b1;
        din = f;
        @(posedge clk40);
        #1;
        dataValid = 1'b0;
        clearCounters = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk40);
        #1;
    endtask

    initial begin
        idle(2);
        chk("rst_noError", 32'(noError), 1);
        chk("rst_errCode", 32'(errCode), 0);
        chk("rst_errCount", 32'(errCount), 0);
        chk("rst_packetCount", 32'(packetCount), 0);
        chk("rst_chipIdError", 32'(chipIdError), 0);
        chk("rst_refChipId", 32'(refChipId), 0);
        reset = 1'b0;
        idle(1);

        send(FILL); chk("good_fill", 32'(noError), 1);
        send(HDR);  chk("good_hdr", 32'(noError), 1);
        for (int i = 0; i < 3; i++) begin
            send(DAT); chk("good_data", 32'(noError), 1);
        end
        send(trl(17'h1ABCD)); chk("good_trl", 32'(noError), 1);
        send(FILL);
        chk("good_noError", 32'(noError), 1);
        chk("good_packetCount", 32'(packetCount), 1);
        chk("good_errCount", 32'(errCount), 0);
        chk("good_refChipId", 32'(refChipId), 32'h1ABCD);
        chk("good_errCode", 32'(errCode), 0);

        send(HDR);
        send(FILL);
        chk("seq1_noError", 32'(noError), 0);
        chk("seq1_errCode", 32'(errCode), 1);
        chk("seq1_errCount", 32'(errCount), 1);
        idle(2);
        chk("seq1_gap_noError", 32'(noError), 0);
        send(trl(17'h1ABCD));
        chk("resync_noError", 32'(noError), 1);
        chk("resync_ignored", 32'(packetCount), 1);
        send(trl(17'h1ABCD));
        chk("unknown_trl_noError", 32'(noError), 1);
        chk("unknown_trl_packet", 32'(packetCount), 2);

        send(FILL);
        send(HDR);
        for (int i = 0; i < 4; i++) begin
            send(DAT); chk("hits_in_limit", 32'(noError), 1);
        end
        send(DAT);
        chk("ovf_noError", 32'(noError), 0);
        chk("ovf_errCode", 32'(errCode), 3);
        chk("ovf_errCount", 32'(errCount), 2);
        send(FILL);
        chk("ovf_resync", 32'(noError), 1);

        clearCounters = 1'b1;
        idle(1);
        clearCounters = 1'b0;
        chk("clr_errCount", 32'(errCount), 0);
        chk("clr_packetCount", 32'(packetCount), 0);
        chk("clr_refChipId", 32'(refChipId), 0);
        send(HDR); send(DAT); send(trl(17'h00001)); send(FILL);
        chk("cid_ref", 32'(refChipId), 1);
        chk("cid_noerr_yet", 32'(chipIdError), 0);
        send(HDR); send(DAT); send(trl(17'h00002));
        chk("cid_noError", 32'(noError), 1);
        send(FILL);
        chk("cid_chipIdError", 32'(chipIdError), 1);
        chk("cid_errCode", 32'(errCode), 4);
        chk("cid_errCount", 32'(errCount), 0);
        chk("cid_packetCount", 32'(packetCount), 2);
        chk("cid_refKept", 32'(refChipId), 1);

        send(HDR); send(DAT); send(trl(17'h00001));
        chk("trl_match_errCode", 32'(errCode), 4);
        idle(3);
        send(trl(17'h00001));
        chk("seq2_noError", 32'(noError), 0);
        chk("seq2_errCode", 32'(errCode), 2);
        chk("seq2_errCount", 32'(errCount), 1);
        chk("seq2_packetCount", 32'(packetCount), 3);
        idle(3);
        chk("seq2_gap_noError", 32'(noError), 0);
        chk("seq2_gap_errCode", 32'(errCode), 2);
        send(FILL);
        chk("seq2_resync", 32'(noError), 1);

        clearCounters = 1'b1;
        idle(1);
        clearCounters = 1'b0;
        for (int i = 0; i < 18; i++) begin
            send(HDR); send(FILL); send(FILL);
        end
        chk("sat_errCount", 32'(errCount), 15);
        chk("sat_errCode", 32'(errCode), 1);
        send(HDR);
        clearCounters = 1'b1;
        send(FILL);
        chk("clrwin_errCount", 32'(errCount), 0);
        chk("clrwin_errCode", 32'(errCode), 0);
        chk("clrwin_noError", 32'(noError), 0);
        send(FILL);
        chk("clrwin_resync", 32'(noError), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
